// File: rtl/note_seq.sv
// note_seq: song-table note sequencer; plays {note, rest, dur} entries as
// freq_sel/tone_en for dur*TickDiv cycles each, stopping at a dur==0 marker.
module note_seq #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    parameter int DurWidth  = 8,
    parameter int TickDiv   = 600000
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(Depth)-1:0] wr_addr,
    input  logic [DataWidth-1:0]     wr_note,
    input  logic                     wr_rest,
    input  logic [DurWidth-1:0]      wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [DataWidth-1:0]     freq_sel,
    output logic                     tone_en,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(Depth)-1:0] note_idx
);
    localparam int AW = $clog2(Depth);
    localparam int TW = $clog2(TickDiv);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    logic [DataWidth-1:0] note_q [Depth];
    logic [DurWidth-1:0]  dur_q  [Depth];
    logic                 rest_q [Depth];

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [DataWidth-1:0] freq_q, freq_d;
    logic                 tone_q, tone_d;
    logic                 done_q, done_d;
    logic [DurWidth-1:0]  len_q, len_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [DurWidth-1:0]  cnt_q, cnt_d;
    logic                 wrap, last;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            note_q <= '{default: '0};
            dur_q  <= '{default: '0};
            rest_q <= '{default: 1'b0};
        end else if (wr_en) begin
            note_q[wr_addr] <= wr_note;
            dur_q[wr_addr]  <= wr_dur;
            rest_q[wr_addr] <= wr_rest;
        end
    end

    assign wrap = tick_q == TW'(TickDiv - 1);
    assign last = cnt_q == len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        freq_d  = freq_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        len_d   = len_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = IDLE;
            tone_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        idx_d   = '0;
                    end
                end
                FETCH: begin
                    if (dur_q[idx_q] != '0) begin
                        state_d = PLAY;
                        freq_d  = note_q[idx_q];
                        tone_d  = ~rest_q[idx_q];
                        len_d   = dur_q[idx_q];
                        tick_d  = '0;
                        cnt_d   = '0;
                    end else if (loop && idx_q != '0) begin
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        tone_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                PLAY: begin
                    tick_d = wrap ? '0 : tick_q + 1'b1;
                    if (wrap && !last) cnt_d = cnt_q + 1'b1;
                    if (wrap && last) begin
                        idx_d = idx_q + 1'b1;
                        // wrapping past the last entry ends the song unless looping
                        if (idx_q == AW'(Depth - 1) && !loop) begin
                            state_d = IDLE;
                            tone_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            freq_q  <= '0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            tick_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
            len_q   <= len_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    assign freq_sel = freq_q;
    assign tone_en  = tone_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign note_idx = idx_q;
endmodule

// File: tb/tb_note_seq.sv
// tb_note_seq: per-cycle vector table for note_seq (TickDiv=4, Depth=16);
// each record holds the inputs for one clock edge and the outputs expected after it.
module tb_note_seq;
    logic       clk_in = 1'b0;
    logic       rst = 1'b1, wr_en = 1'b0, wr_rest = 1'b0;
    logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [3:0] wr_addr = '0, note_idx;
    logic [7:0] wr_note = '0, wr_dur = '0, freq_sel;
    logic       tone_en, busy, done;

    note_seq #(.DataWidth(8), .Depth(16), .DurWidth(8), .TickDiv(4)) dut (
        .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_note(wr_note), .wr_rest(wr_rest), .wr_dur(wr_dur),
        .start(start), .stop(stop), .loop(loop),
        .freq_sel(freq_sel), .tone_en(tone_en), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       rst, start, stop, loop, wr_en;
        logic [3:0] wa;
        logic [7:0] wn;
        logic       wr;
        logic [7:0] wd;
        logic [7:0] freq;
        logic       tone, busy, done;
        logic [3:0] idx;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   fails = 0;

    function automatic vec_t mk(int s, int st, int lp, int fr, int tn, int bs, int dn, int ix);
        vec_t v;
        v = '0;
        v.rst   = 1'b1;
        v.start = s[0];
        v.stop  = st[0];
        v.loop  = lp[0];
        v.freq  = fr[7:0];
        v.tone  = tn[0];
        v.busy  = bs[0];
        v.done  = dn[0];
        v.idx   = ix[3:0];
        return v;
    endfunction

    function automatic vec_t setw(vec_t v, int a, int nt, int r, int d);
        vec_t o;
        o = v;
        o.wr_en = 1'b1;
        o.wa    = a[3:0];
        o.wn    = nt[7:0];
        o.wr    = r[0];
        o.wd    = d[7:0];
        return o;
    endfunction

    task automatic rep(input vec_t v, input int n);
        for (int k = 0; k < n; k++) q.push_back(v);
    endtask

    task automatic run(input string name);
        logic [14:0] got, exp;
        foreach (q[k]) begin
            rst = q[k].rst; start = q[k].start; stop = q[k].stop; loop = q[k].loop;
            wr_en = q[k].wr_en; wr_addr = q[k].wa; wr_note = q[k].wn;
            wr_rest = q[k].wr; wr_dur = q[k].wd;
            @(posedge clk_in);
            #1;
            got = {freq_sel, tone_en, busy, done, note_idx};
            exp = {q[k].freq, q[k].tone, q[k].busy, q[k].done, q[k].idx};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s vec %0d: {freq,tone,busy,done,idx} got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d",
                         name, k, got[14:7], got[6], got[5], got[4], got[3:0],
                         exp[14:7], exp[6], exp[5], exp[4], exp[3:0]);
            end
        end
        q.delete();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        vec_t rv, v;
        rv = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rv.rst = 1'b0;

        // two-note song, start ignored while busy
        q.push_back(rv);
        q.push_back(setw(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 'h10, 0, 2));
        q.push_back(setw(mk(0, 0, 0, 0, 0, 0, 0, 0), 1, 'h20, 1, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        rep(mk(0, 0, 0, 'h10, 1, 1, 0, 0), 3);
        q.push_back(mk(1, 0, 0, 'h10, 1, 1, 0, 0));
        rep(mk(0, 0, 0, 'h10, 1, 1, 0, 0), 4);
        q.push_back(mk(0, 0, 0, 'h10, 1, 1, 0, 1));
        rep(mk(0, 0, 0, 'h20, 0, 1, 0, 1), 4);
        q.push_back(mk(0, 0, 0, 'h20, 0, 1, 0, 2));
        q.push_back(mk(0, 0, 0, 'h20, 0, 0, 1, 2));
        q.push_back(mk(0, 0, 0, 'h20, 0, 0, 0, 2));
        run("basic");

        // loop back at end marker, then stop
        q.push_back(mk(1, 0, 1, 'h20, 0, 1, 0, 0));
        rep(mk(0, 0, 1, 'h10, 1, 1, 0, 0), 8);
        q.push_back(mk(0, 0, 1, 'h10, 1, 1, 0, 1));
        rep(mk(0, 0, 1, 'h20, 0, 1, 0, 1), 4);
        q.push_back(mk(0, 0, 1, 'h20, 0, 1, 0, 2));
        q.push_back(mk(0, 0, 1, 'h20, 0, 1, 0, 0));
        rep(mk(0, 0, 1, 'h10, 1, 1, 0, 0), 3);
        q.push_back(mk(0, 1, 1, 'h10, 0, 0, 0, 0));
        rep(mk(0, 0, 0, 'h10, 0, 0, 0, 0), 2);
        run("loop");

        // rewrite entry 0 while it plays
        q.push_back(mk(1, 0, 1, 'h10, 0, 1, 0, 0));
        q.push_back(mk(0, 0, 1, 'h10, 1, 1, 0, 0));
        q.push_back(setw(mk(0, 0, 1, 'h10, 1, 1, 0, 0), 0, 'h55, 0, 2));
        rep(mk(0, 0, 1, 'h10, 1, 1, 0, 0), 6);
        q.push_back(mk(0, 0, 1, 'h10, 1, 1, 0, 1));
        rep(mk(0, 0, 1, 'h20, 0, 1, 0, 1), 4);
        q.push_back(mk(0, 0, 1, 'h20, 0, 1, 0, 2));
        q.push_back(mk(0, 0, 1, 'h20, 0, 1, 0, 0));
        rep(mk(0, 0, 1, 'h55, 1, 1, 0, 0), 2);
        q.push_back(mk(0, 1, 0, 'h55, 0, 0, 0, 0));
        run("overwrite");

        // full table, index wrap ends song
        q.push_back(rv);
        for (int i = 0; i < 16; i++) q.push_back(setw(mk(0, 0, 0, 0, 0, 0, 0, 0), i, i + 1, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 16; i++) begin
            if (i > 0) q.push_back(mk(0, 0, 0, i, 1, 1, 0, i));
            rep(mk(0, 0, 0, i + 1, 1, 1, 0, i), 4);
        end
        q.push_back(mk(0, 0, 0, 16, 0, 0, 1, 0));
        rep(mk(0, 0, 0, 16, 0, 0, 0, 0), 2);
        run("full");

        // empty table, start+stop, reset mid-note overriding start and write
        q.push_back(rv);
        q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(setw(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 'h33, 0, 1));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        rep(mk(0, 0, 0, 'h33, 1, 1, 0, 0), 2);
        v = setw(rv, 1, 'h77, 0, 3);
        v.start = 1'b1;
        q.push_back(v);
        q.push_back(setw(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 'h44, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        rep(mk(0, 0, 0, 'h44, 1, 1, 0, 0), 4);
        q.push_back(mk(0, 0, 0, 'h44, 1, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 'h44, 0, 0, 1, 1));
        q.push_back(mk(0, 0, 0, 'h44, 0, 0, 0, 1));
        run("reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
